// File: rtl/id_ex_if.sv
// Decode-to-execute bus: ID-side operands/control in, EX-side registered copies,
// the load-use stall request and the performance counters out.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [DATA_W-1:0] id_ext;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_wa;
    logic [CTRL_W-1:0] id_ctrl;
    logic              flush;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_ext;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_wa;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              hazard_stall;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_pc, id_rd1, id_rd2, id_ext, id_rs, id_rt, id_wa, id_ctrl, flush,
        input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_ext, ex_rs, ex_rt, ex_wa, ex_ctrl,
        input  hazard_stall, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rd1, id_rd2, id_ext, id_rs, id_rt, id_wa, id_ctrl, flush,
        output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_ext, ex_rs, ex_rt, ex_wa, ex_ctrl,
        output hazard_stall, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands/control, inserts a bubble on
// load-use hazards or flush, and keeps saturating stall/flush event counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    id_ex_if.slave s_bus
);
    localparam int MEM2R_BIT = 10;

    logic              r_ex_valid;
    logic [DATA_W-1:0] r_ex_pc;
    logic [DATA_W-1:0] r_ex_rd1;
    logic [DATA_W-1:0] r_ex_rd2;
    logic [DATA_W-1:0] r_ex_ext;
    logic [REG_AW-1:0] r_ex_rs;
    logic [REG_AW-1:0] r_ex_rt;
    logic [REG_AW-1:0] r_ex_wa;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_hazard_raw;
    logic w_hazard;
    logic w_bubble;

    // A load in EX whose destination is read by the valid ID instruction; $zero never hazards.
    assign w_hazard_raw = r_ex_valid & r_ex_ctrl[MEM2R_BIT] & s_bus.id_valid
                        & (r_ex_wa != '0)
                        & ((r_ex_wa == s_bus.id_rs) | (r_ex_wa == s_bus.id_rt));
    // Flush already kills the ID instruction, so there is nothing to hold.
    assign w_hazard = w_hazard_raw & ~s_bus.flush;
    assign w_bubble = s_bus.flush | w_hazard;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_pc    <= '0;
            r_ex_rd1   <= '0;
            r_ex_rd2   <= '0;
            r_ex_ext   <= '0;
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
            r_ex_wa    <= '0;
            r_ex_ctrl  <= '0;
        end else if (w_bubble) begin
            r_ex_valid <= 1'b0;
            r_ex_pc    <= '0;
            r_ex_rd1   <= '0;
            r_ex_rd2   <= '0;
            r_ex_ext   <= '0;
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
            r_ex_wa    <= '0;
            r_ex_ctrl  <= '0;
        end else begin
            r_ex_valid <= s_bus.id_valid;
            r_ex_pc    <= s_bus.id_pc;
            r_ex_rd1   <= s_bus.id_rd1;
            r_ex_rd2   <= s_bus.id_rd2;
            r_ex_ext   <= s_bus.id_ext;
            r_ex_rs    <= s_bus.id_rs;
            r_ex_rt    <= s_bus.id_rt;
            r_ex_wa    <= s_bus.id_wa;
            r_ex_ctrl  <= s_bus.id_ctrl;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hazard && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (s_bus.flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign s_bus.ex_valid     = r_ex_valid;
    assign s_bus.ex_pc        = r_ex_pc;
    assign s_bus.ex_rd1       = r_ex_rd1;
    assign s_bus.ex_rd2       = r_ex_rd2;
    assign s_bus.ex_ext       = r_ex_ext;
    assign s_bus.ex_rs        = r_ex_rs;
    assign s_bus.ex_rt        = r_ex_rt;
    assign s_bus.ex_wa        = r_ex_wa;
    assign s_bus.ex_ctrl      = r_ex_ctrl;
    assign s_bus.hazard_stall = w_hazard;
    assign s_bus.stall_cnt    = r_stall_cnt;
    assign s_bus.flush_cnt    = r_flush_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a vector table for pass-through/hazard/flush behaviour,
// then hand sequences for asynchronous reset and counter saturation.
module tb_id_ex_stage;
    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_rd1, id_rd2, id_ext;
    logic [4:0]  id_rs, id_rt, id_wa;
    logic [11:0] id_ctrl;
    logic        flush;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_if #(.CNT_W(16)) if_main ();
    id_ex_if #(.CNT_W(4))  if_sat ();

    assign if_main.id_valid = id_valid;
    assign if_main.id_pc    = id_pc;
    assign if_main.id_rd1   = id_rd1;
    assign if_main.id_rd2   = id_rd2;
    assign if_main.id_ext   = id_ext;
    assign if_main.id_rs    = id_rs;
    assign if_main.id_rt    = id_rt;
    assign if_main.id_wa    = id_wa;
    assign if_main.id_ctrl  = id_ctrl;
    assign if_main.flush    = flush;

    assign if_sat.id_valid = id_valid;
    assign if_sat.id_pc    = id_pc;
    assign if_sat.id_rd1   = id_rd1;
    assign if_sat.id_rd2   = id_rd2;
    assign if_sat.id_ext   = id_ext;
    assign if_sat.id_rs    = id_rs;
    assign if_sat.id_rt    = id_rt;
    assign if_sat.id_wa    = id_wa;
    assign if_sat.id_ctrl  = id_ctrl;
    assign if_sat.flush    = flush;

    id_ex_stage #(.CNT_W(16)) u_dut (.i_clk(clk), .i_rst_n(rst_n), .s_bus(if_main));
    id_ex_stage #(.CNT_W(4))  u_sat (.i_clk(clk), .i_rst_n(rst_n), .s_bus(if_sat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: act=running req=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: act=%0h req=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] pc, rd1, rd2, ext;
        logic [4:0]  rs, rt, wa;
        logic [11:0] ctrl;
        logic        fl;
        logic        e_stall;
        logic        e_bub;
        int          e_scnt;
        int          e_fcnt;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic vld, input logic [31:0] pc, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [31:0] ext,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa,
                                input logic [11:0] ctrl, input logic fl,
                                input logic e_stall, input logic e_bub,
                                input int e_scnt, input int e_fcnt);
        vec_t v;
        v.vld = vld; v.pc = pc; v.rd1 = rd1; v.rd2 = rd2; v.ext = ext;
        v.rs = rs; v.rt = rt; v.wa = wa; v.ctrl = ctrl; v.fl = fl;
        v.e_stall = e_stall; v.e_bub = e_bub; v.e_scnt = e_scnt; v.e_fcnt = e_fcnt;
        return v;
    endfunction

    task automatic check_ex_zero(input string tag);
        chk({tag, " ex_valid"}, 32'(if_main.ex_valid), 32'd0);
        chk({tag, " ex_pc"},    if_main.ex_pc,         32'd0);
        chk({tag, " ex_rd1"},   if_main.ex_rd1,        32'd0);
        chk({tag, " ex_rd2"},   if_main.ex_rd2,        32'd0);
        chk({tag, " ex_ext"},   if_main.ex_ext,        32'd0);
        chk({tag, " ex_rs"},    32'(if_main.ex_rs),    32'd0);
        chk({tag, " ex_rt"},    32'(if_main.ex_rt),    32'd0);
        chk({tag, " ex_wa"},    32'(if_main.ex_wa),    32'd0);
        chk({tag, " ex_ctrl"},  32'(if_main.ex_ctrl),  32'd0);
    endtask

    initial begin
        //            vld pc         rd1  rd2  ext  rs  rt  wa  ctrl     fl stall bub scnt fcnt
        vecs[0]  = mk(1, 32'h3000, 5,   7,   9,   1,  2,  3,  12'h800, 0, 0, 0, 0, 0); // T2 pass-through
        vecs[1]  = mk(1, 32'h3004, 10,  0,   4,   3,  8,  8,  12'hC00, 0, 0, 0, 0, 0); // lw $8
        vecs[2]  = mk(1, 32'h3008, 11,  12,  13,  8,  1,  9,  12'h800, 0, 1, 1, 1, 0); // T3 use of $8
        vecs[3]  = mk(1, 32'h3008, 11,  12,  13,  8,  1,  9,  12'h800, 0, 0, 0, 1, 0); // re-presented
        vecs[4]  = mk(1, 32'h300C, 20,  21,  22,  2,  0,  0,  12'hC00, 0, 0, 0, 1, 0); // lw $0
        vecs[5]  = mk(1, 32'h3010, 30,  31,  32,  0,  0,  4,  12'h800, 0, 0, 0, 1, 0); // T4 reads $0
        vecs[6]  = mk(1, 32'h3014, 40,  41,  42,  1,  2,  5,  12'hC00, 0, 0, 0, 1, 0); // lw $5
        vecs[7]  = mk(1, 32'h3018, 50,  51,  52,  6,  5,  7,  12'h800, 1, 0, 1, 1, 1); // T5 flush+hazard
        vecs[8]  = mk(1, 32'h301C, 60,  61,  62,  1,  2,  6,  12'hC00, 0, 0, 0, 1, 1); // lw $6
        vecs[9]  = mk(0, 32'h3020, 70,  71,  72,  6,  6,  7,  12'h800, 0, 0, 0, 1, 1); // invalid ID: no hazard
        vecs[10] = mk(1, 32'h3024, 80,  81,  82,  1,  2,  10, 12'hC00, 0, 0, 0, 1, 1); // lw $10
        vecs[11] = mk(1, 32'h3028, 90,  91,  92,  10, 3,  11, 12'hC00, 0, 1, 1, 2, 1); // lw $11 uses $10
        vecs[12] = mk(1, 32'h3028, 90,  91,  92,  10, 3,  11, 12'hC00, 0, 0, 0, 2, 1); // re-presented
        vecs[13] = mk(1, 32'h302C, 100, 101, 102, 4,  11, 12, 12'h800, 0, 1, 1, 3, 1); // uses $11 via rt
        vecs[14] = mk(1, 32'h302C, 100, 101, 102, 4,  11, 12, 12'h800, 0, 0, 0, 3, 1); // re-presented

        rst_n = 1'b0;
        id_valid = 1'b0; id_pc = '0; id_rd1 = '0; id_rd2 = '0; id_ext = '0;
        id_rs = '0; id_rt = '0; id_wa = '0; id_ctrl = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_ex_zero("reset");
        chk("reset hazard_stall", 32'(if_main.hazard_stall), 32'd0);
        chk("reset stall_cnt",    32'(if_main.stall_cnt),    32'd0);
        chk("reset flush_cnt",    32'(if_main.flush_cnt),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            id_valid = vecs[i].vld; id_pc = vecs[i].pc; id_rd1 = vecs[i].rd1;
            id_rd2 = vecs[i].rd2; id_ext = vecs[i].ext; id_rs = vecs[i].rs;
            id_rt = vecs[i].rt; id_wa = vecs[i].wa; id_ctrl = vecs[i].ctrl; flush = vecs[i].fl;
            #1;
            chk($sformatf("v%0d hazard_stall", i), 32'(if_main.hazard_stall), 32'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            if (vecs[i].e_bub) begin
                check_ex_zero($sformatf("v%0d bubble", i));
            end else begin
                chk($sformatf("v%0d ex_valid", i), 32'(if_main.ex_valid), 32'(vecs[i].vld));
                chk($sformatf("v%0d ex_pc", i),    if_main.ex_pc,         vecs[i].pc);
                chk($sformatf("v%0d ex_rd1", i),   if_main.ex_rd1,        vecs[i].rd1);
                chk($sformatf("v%0d ex_rd2", i),   if_main.ex_rd2,        vecs[i].rd2);
                chk($sformatf("v%0d ex_ext", i),   if_main.ex_ext,        vecs[i].ext);
                chk($sformatf("v%0d ex_rs", i),    32'(if_main.ex_rs),    32'(vecs[i].rs));
                chk($sformatf("v%0d ex_rt", i),    32'(if_main.ex_rt),    32'(vecs[i].rt));
                chk($sformatf("v%0d ex_wa", i),    32'(if_main.ex_wa),    32'(vecs[i].wa));
                chk($sformatf("v%0d ex_ctrl", i),  32'(if_main.ex_ctrl),  32'(vecs[i].ctrl));
            end
            chk($sformatf("v%0d stall_cnt", i), 32'(if_main.stall_cnt), 32'(vecs[i].e_scnt));
            chk($sformatf("v%0d flush_cnt", i), 32'(if_main.flush_cnt), 32'(vecs[i].e_fcnt));
        end

        // T1: asynchronous reset mid-cycle while EX holds a load
        @(negedge clk);
        flush = 1'b0; id_valid = 1'b1; id_pc = 32'h4000; id_rd1 = 32'h55; id_rd2 = 32'h66;
        id_ext = 32'h77; id_rs = 5'd1; id_rt = 5'd2; id_wa = 5'd9; id_ctrl = 12'hC00;
        @(posedge clk);
        #1;
        chk("T1 pre ex_ctrl", 32'(if_main.ex_ctrl), 32'hC00);
        id_rs = 5'd9;
        #1;
        chk("T1 pre hazard_stall", 32'(if_main.hazard_stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_ex_zero("T1 async");
        chk("T1 hazard_stall", 32'(if_main.hazard_stall), 32'd0);
        chk("T1 stall_cnt",    32'(if_main.stall_cnt),    32'd0);
        chk("T1 flush_cnt",    32'(if_main.flush_cnt),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T6: flush held for 20 cycles; the 4-bit counter must stop at 15
        flush = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("T6 sat flush_cnt",  32'(if_sat.flush_cnt),   32'd15);
        chk("T6 main flush_cnt", 32'(if_main.flush_cnt),  32'd20);
        chk("T6 stall_cnt",      32'(if_main.stall_cnt),  32'd0);
        chk("T6 hazard_stall",   32'(if_main.hazard_stall), 32'd0);
        chk("T6 ex_valid",       32'(if_main.ex_valid),   32'd0);
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        #1;
        chk("T6 after ex_pc",   if_main.ex_pc,           32'h4000);
        chk("T6 after ex_ctrl", 32'(if_main.ex_ctrl),    32'hC00);
        chk("T6 sat hold",      32'(if_sat.flush_cnt),   32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
